// File: rtl/dds_tone_gen.sv
// DDS tone source: phase accumulator, quarter-wave sine ROM,
// amplitude scaling and offset-binary output, one sample per DAC frame.
module dds_tone_gen #(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int OUT_W   = 16
) (
    input  logic               CLK_100,
    input  logic               RESET_N,
    input  logic               ENABLE,
    input  logic [PHASE_W-1:0] FTW,
    input  logic               FTW_LOAD,
    input  logic [7:0]         AMP,
    input  logic               TR_CK,
    output logic [OUT_W-1:0]   DATA16,
    output logic               SAMPLE_STB
);

    localparam int LUT_N = 1 << LUT_AW;

    // Sample taken mid-step so the quarter wave never hits exactly 0 or full scale.
    function automatic logic [14:0] qsin(input int k);
        real x;
        x = 32767.0 * $sin(2.0 * 3.14159265358979 * (real'(k) + 0.5)
                           / real'(4 * LUT_N));
        return 15'($rtoi(x + 0.5));
    endfunction

    logic [14:0] rom [LUT_N];

    for (genvar k = 0; k < LUT_N; k++) begin : g_rom
        localparam logic [14:0] VAL = qsin(k);
        assign rom[k] = VAL;
    end

    logic               tr_q;
    logic               tick;
    logic [PHASE_W-1:0] phase_acc;
    logic [PHASE_W-1:0] ftw_act;
    logic [PHASE_W-1:0] ftw_pend;
    logic               pend_valid;
    logic               v1, v2, v3, v4;
    logic [LUT_AW-1:0]  addr2;
    logic [LUT_AW-1:0]  idx;
    logic [1:0]         quad;
    logic               neg2, neg3, neg4;
    logic               en2, en3, en4;
    logic [14:0]        mag3;
    logic [14:0]        scaled4;
    logic [22:0]        prod;

    assign tick = TR_CK & ~tr_q;
    assign quad = phase_acc[PHASE_W-1 -: 2];
    assign idx  = phase_acc[PHASE_W-3 -: LUT_AW];
    assign prod = 23'(mag3) * 23'({1'b0, AMP} + 9'd1);

    always_ff @(posedge CLK_100 or negedge RESET_N) begin
        if (!RESET_N) begin
            tr_q       <= 1'b0;
            phase_acc  <= '0;
            ftw_act    <= '0;
            ftw_pend   <= '0;
            pend_valid <= 1'b0;
            v1         <= 1'b0;
        end else begin
            tr_q <= TR_CK;
            v1   <= tick;
            if (tick) begin
                phase_acc <= ENABLE ? phase_acc + ftw_act : '0;
                if (pend_valid) begin
                    ftw_act <= ftw_pend;
                end
            end
            // A load coinciding with a tick stays pending for the next tick.
            if (FTW_LOAD) begin
                ftw_pend   <= FTW;
                pend_valid <= 1'b1;
            end else if (tick) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_100 or negedge RESET_N) begin
        if (!RESET_N) begin
            v2      <= 1'b0;
            v3      <= 1'b0;
            v4      <= 1'b0;
            addr2   <= '0;
            neg2    <= 1'b0;
            neg3    <= 1'b0;
            neg4    <= 1'b0;
            en2     <= 1'b0;
            en3     <= 1'b0;
            en4     <= 1'b0;
            mag3    <= '0;
            scaled4 <= '0;
        end else begin
            v2      <= v1;
            v3      <= v2;
            v4      <= v3;
            addr2   <= quad[0] ? ~idx : idx;
            neg2    <= quad[1];
            en2     <= ENABLE;
            mag3    <= rom[addr2];
            neg3    <= neg2;
            en3     <= en2;
            scaled4 <= 15'(prod >> 8);
            neg4    <= neg3;
            en4     <= en3;
        end
    end

    always_ff @(posedge CLK_100 or negedge RESET_N) begin
        if (!RESET_N) begin
            DATA16     <= 16'h8000;
            SAMPLE_STB <= 1'b0;
        end else begin
            SAMPLE_STB <= v4;
            if (v4) begin
                if (!en4) begin
                    DATA16 <= 16'h8000;
                end else if (neg4) begin
                    DATA16 <= 16'h8000 - {1'b0, scaled4};
                end else begin
                    DATA16 <= 16'h8000 + {1'b0, scaled4};
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_tone_gen.sv
// Bench for dds_tone_gen: sine/phase model checked every cycle
// plus hand-computed sample values for directed scenarios.
module tb_dds_tone_gen;

    logic        CLK_100  = 1'b0;
    logic        RESET_N  = 1'b0;
    logic        ENABLE   = 1'b0;
    logic [31:0] FTW      = '0;
    logic        FTW_LOAD = 1'b0;
    logic [7:0]  AMP      = 8'd255;
    logic        TR_CK    = 1'b0;
    logic [15:0] DATA16;
    logic        SAMPLE_STB;

    dds_tone_gen dut (
        .CLK_100    (CLK_100),
        .RESET_N    (RESET_N),
        .ENABLE     (ENABLE),
        .FTW        (FTW),
        .FTW_LOAD   (FTW_LOAD),
        .AMP        (AMP),
        .TR_CK      (TR_CK),
        .DATA16     (DATA16),
        .SAMPLE_STB (SAMPLE_STB)
    );

    always #5 CLK_100 = ~CLK_100;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected sample straight from the sine definition.
    function automatic logic [15:0] model_sample(input logic [31:0] ph,
                                                 input logic en,
                                                 input logic [7:0] amp);
        int  quad, f, mag, sc;
        real ang;
        quad = int'(ph[31:30]);
        f    = int'(ph[29:22]);
        if (quad % 2 == 1) f = 255 - f;
        ang = 2.0 * 3.141592653589793 * (f + 0.5) / 1024.0;
        mag = $rtoi(32767.0 * $sin(ang) + 0.5);
        sc  = (mag * (int'(amp) + 1)) / 256;
        if (!en) return 16'h8000;
        return (quad >= 2) ? 16'(32768 - sc) : 16'(32768 + sc);
    endfunction

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    exp_t        eq[$];
    logic [15:0] got[$];
    int          cyc     = 0;
    logic [31:0] m_phase = '0;
    logic [31:0] m_act   = '0;
    logic [31:0] m_pend  = '0;
    bit          m_pv    = 1'b0;
    bit          m_trq   = 1'b0;
    logic [15:0] m_out   = 16'h8000;
    bit          es      = 1'b0;

    initial forever begin
        @(posedge CLK_100 or negedge RESET_N);
        if (!RESET_N) begin
            m_phase = '0;
            m_act   = '0;
            m_pend  = '0;
            m_pv    = 1'b0;
            m_trq   = 1'b0;
            eq.delete();
        end else begin
            cyc++;
            if (TR_CK && !m_trq) begin
                m_phase = ENABLE ? m_phase + m_act : '0;
                if (m_pv) begin
                    m_act = m_pend;
                    m_pv  = 1'b0;
                end
                eq.push_back('{cyc + 4, model_sample(m_phase, ENABLE, AMP)});
            end
            if (FTW_LOAD) begin
                m_pend = FTW;
                m_pv   = 1'b1;
            end
            m_trq = TR_CK;
        end
    end

    initial forever begin
        @(negedge CLK_100);
        if (!RESET_N) begin
            m_out = 16'h8000;
            chk("rst_data", DATA16, 16'h8000);
            chk("rst_stb", SAMPLE_STB, 0);
        end else begin
            es = eq.size() > 0 && eq[0].due == cyc;
            if (es) begin
                m_out = eq[0].val;
                void'(eq.pop_front());
            end
            chk("stb", SAMPLE_STB, es);
            chk("data", DATA16, m_out);
            if (SAMPLE_STB) got.push_back(DATA16);
        end
    end

    task automatic step();
        @(posedge CLK_100);
        #1;
    endtask

    task automatic load(input logic [31:0] w);
        FTW      = w;
        FTW_LOAD = 1'b1;
        step();
        FTW_LOAD = 1'b0;
    endtask

    task automatic tick(input int hi, input bit ld, input logic [31:0] w);
        TR_CK = 1'b1;
        if (ld) begin
            FTW      = w;
            FTW_LOAD = 1'b1;
        end
        step();
        FTW_LOAD = 1'b0;
        repeat (hi - 1) step();
        TR_CK = 1'b0;
        repeat (10) step();
    endtask

    task automatic samp(input string name, input bit lit,
                        input logic [15:0] v, input bit ld,
                        input logic [31:0] w);
        int n;
        n = got.size();
        tick(2, ld, w);
        chk({name, "_count"}, got.size() - n, 1);
        if (lit) chk(name, got[got.size() - 1], v);
    endtask

    initial begin
        int n;
        repeat (3) step();
        chk("reset_data", DATA16, 16'h8000);
        chk("reset_stb", SAMPLE_STB, 0);
        RESET_N = 1'b1;
        repeat (3) step();

        ENABLE = 1'b1;
        AMP    = 8'd255;
        load(32'h4000_0000);
        samp("walk0", 1, 16'h8065, 0, 0);
        samp("walk1", 1, 16'hFFFF, 0, 0);
        samp("walk2", 1, 16'h7F9B, 0, 0);
        samp("walk3", 1, 16'h0001, 0, 0);
        samp("walk4", 1, 16'h8065, 0, 0);

        AMP = 8'd127;
        samp("amp_peak", 1, 16'hBFFF, 0, 0);
        samp("amp_zneg", 1, 16'h7FCE, 0, 0);
        samp("amp_trough", 1, 16'h4001, 0, 0);
        samp("amp_zpos", 1, 16'h8032, 0, 0);
        samp("amp_peak2", 1, 16'hBFFF, 0, 0);

        AMP = 8'd255;
        samp("sw_same_tick", 1, 16'h7F9B, 1, 32'h2000_0000);
        samp("sw_old_ftw", 1, 16'h0001, 0, 0);
        samp("sw_new_ftw", 0, 16'h0000, 0, 0);
        samp("sw_wrap", 1, 16'h8065, 0, 0);

        load(32'h1000_0000);
        load(32'h6000_0000);
        samp("dbl_a", 0, 16'h0000, 0, 0);
        samp("dbl_b", 1, 16'h7F9B, 0, 0);
        samp("dbl_c", 0, 16'h0000, 0, 0);
        samp("dbl_d", 1, 16'hFFFF, 0, 0);

        load(32'h4000_0000);
        ENABLE = 1'b0;
        samp("dis0", 1, 16'h8000, 0, 0);
        samp("dis1", 1, 16'h8000, 0, 0);
        ENABLE = 1'b1;
        samp("reen0", 1, 16'hFFFF, 0, 0);
        samp("reen1", 1, 16'h7F9B, 0, 0);

        n = got.size();
        tick(50, 0, 0);
        chk("stretch_count", got.size() - n, 1);
        chk("stretch_val", got[got.size() - 1], 16'h0001);
        samp("stretch_next", 1, 16'h8065, 0, 0);

        n = got.size();
        repeat (3) begin
            TR_CK = 1'b1;
            step();
            step();
            TR_CK = 1'b0;
            step();
        end
        repeat (12) step();
        chk("b2b_count", got.size() - n, 3);
        chk("b2b_0", got[n], 16'hFFFF);
        chk("b2b_1", got[n + 1], 16'h7F9B);
        chk("b2b_2", got[n + 2], 16'h0001);

        TR_CK = 1'b1;
        step();
        step();
        TR_CK = 1'b0;
        #3 RESET_N = 1'b0;
        #1;
        chk("midrst_data", DATA16, 16'h8000);
        chk("midrst_stb", SAMPLE_STB, 0);
        step();
        step();
        #2 RESET_N = 1'b1;
        n = got.size();
        repeat (12) step();
        chk("post_rst_quiet", got.size() - n, 0);
        load(32'h4000_0000);
        samp("post_rst0", 1, 16'h8065, 0, 0);
        samp("post_rst1", 1, 16'hFFFF, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
